decode_operand_unit: RTL and testbench



---
 rtl/riscv_pkg.sv | 10 +
 rtl/reg_file.sv | 60 ++++++
 rtl/decode_operand_unit.sv | 87 ++++++++
 tb/tb_decode_operand_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared datapath constants and types for the register-file read side.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned NREGS      = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : riscv_pkg

// File: rtl/reg_file.sv
// Architectural register file: one write port and three combinational read ports
// (rs1, rs2, dbg). Each read port bypasses same-cycle write data. x0 reads as zero.
module reg_file
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = riscv_pkg::XLEN,
    parameter int unsigned NREGS = riscv_pkg::NREGS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_we,
    input  reg_addr_t       i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  reg_addr_t       i_rs1_addr,
    input  reg_addr_t       i_rs2_addr,
    input  reg_addr_t       i_dbg_addr,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic [XLEN-1:0] o_dbg_data
);

    // Only NREGS == 32 is supported, so every 5-bit address maps to an entry.
    logic [XLEN-1:0] r_regs [NREGS];
    reg_addr_t       w_raddr [3];
    logic [XLEN-1:0] w_rdata [3];

    assign w_raddr[0] = i_rs1_addr;
    assign w_raddr[1] = i_rs2_addr;
    assign w_raddr[2] = i_dbg_addr;

    assign o_rs1_data = w_rdata[0];
    assign o_rs2_data = w_rdata[1];
    assign o_dbg_data = w_rdata[2];

    // Storage update; writes to x0 are dropped so x0 stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Read ports: x0 is zero, then write-through bypass, then stored value.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            w_rdata[p] = '0;
            if (w_raddr[p] == '0) begin
                w_rdata[p] = '0;
            end else if (i_we && (i_waddr == w_raddr[p])) begin
                w_rdata[p] = i_wdata;
            end else begin
                w_rdata[p] = r_regs[w_raddr[p]];
            end
        end
    end

endmodule : reg_file

// File: rtl/decode_operand_unit.sv
// Decode-stage operand read: register file plus the D->E operand pipeline register
// with flush, stall, and refresh of stalled operands from the retiring writeback.
module decode_operand_unit
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = riscv_pkg::XLEN,
    parameter int unsigned NREGS = riscv_pkg::NREGS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            D_valid,
    input  logic [4:0]      D_rs1_addr,
    input  logic [4:0]      D_rs2_addr,
    input  logic            W_reg_write,
    input  logic [4:0]      W_rd_addr,
    input  logic [XLEN-1:0] W_rd,
    input  logic            E_stall,
    input  logic            E_flush,
    output logic            E_valid,
    output logic [4:0]      E_rs1_addr,
    output logic [4:0]      E_rs2_addr,
    output logic [XLEN-1:0] E_rs1_data,
    output logic [XLEN-1:0] E_rs2_data,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;
    logic            w_refresh_rs1;
    logic            w_refresh_rs2;

    reg_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_reg_file (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (W_reg_write),
        .i_waddr    (W_rd_addr),
        .i_wdata    (W_rd),
        .i_rs1_addr (D_rs1_addr),
        .i_rs2_addr (D_rs2_addr),
        .i_dbg_addr (dbg_addr),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data),
        .o_dbg_data (dbg_data)
    );

    // A held operand picks up a result retiring to its source register.
    always_comb begin
        w_refresh_rs1 = W_reg_write && (E_rs1_addr != '0) && (E_rs1_addr == W_rd_addr);
        w_refresh_rs2 = W_reg_write && (E_rs2_addr != '0) && (E_rs2_addr == W_rd_addr);
    end

    // E pipeline register: flush beats stall beats capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            E_valid    <= 1'b0;
            E_rs1_addr <= '0;
            E_rs2_addr <= '0;
            E_rs1_data <= '0;
            E_rs2_data <= '0;
        end else if (E_flush) begin
            E_valid    <= 1'b0;
            E_rs1_addr <= '0;
            E_rs2_addr <= '0;
            E_rs1_data <= '0;
            E_rs2_data <= '0;
        end else if (E_stall) begin
            if (w_refresh_rs1) begin
                E_rs1_data <= W_rd;
            end
            if (w_refresh_rs2) begin
                E_rs2_data <= W_rd;
            end
        end else begin
            // Fields are captured even when D_valid is low; consumers gate on E_valid.
            E_valid    <= D_valid;
            E_rs1_addr <= D_rs1_addr;
            E_rs2_addr <= D_rs2_addr;
            E_rs1_data <= w_rs1_data;
            E_rs2_data <= w_rs2_data;
        end
    end

endmodule : decode_operand_unit

// File: tb/tb_decode_operand_unit.sv
// Scoreboard bench for decode_operand_unit: the driver computes the expected E register
// from a register-array model and queues it; the monitor checks it after each edge.
module tb_decode_operand_unit;

    logic        clk;
    logic        rst_n;
    logic        D_valid;
    logic [4:0]  D_rs1_addr;
    logic [4:0]  D_rs2_addr;
    logic        W_reg_write;
    logic [4:0]  W_rd_addr;
    logic [31:0] W_rd;
    logic        E_stall;
    logic        E_flush;
    logic        E_valid;
    logic [4:0]  E_rs1_addr;
    logic [4:0]  E_rs2_addr;
    logic [31:0] E_rs1_data;
    logic [31:0] E_rs2_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    decode_operand_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .D_valid     (D_valid),
        .D_rs1_addr  (D_rs1_addr),
        .D_rs2_addr  (D_rs2_addr),
        .W_reg_write (W_reg_write),
        .W_rd_addr   (W_rd_addr),
        .W_rd        (W_rd),
        .E_stall     (E_stall),
        .E_flush     (E_flush),
        .E_valid     (E_valid),
        .E_rs1_addr  (E_rs1_addr),
        .E_rs2_addr  (E_rs2_addr),
        .E_rs1_data  (E_rs1_data),
        .E_rs2_data  (E_rs2_data),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] d1;
        logic [31:0] d2;
    } e_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] ref_regs [32];
    e_t          ref_e;
    e_t          sb_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural read rule for the current cycle's inputs.
    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (W_reg_write && W_rd_addr == a) return W_rd;
        return ref_regs[a];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
        ref_e = '{v: 1'b0, a1: 5'd0, a2: 5'd0, d1: 32'h0, d2: 32'h0};
    endfunction

    // Drive one cycle of inputs at the falling edge, check dbg, queue expected E.
    task automatic cycle(input logic dv, input logic [4:0] a1, input logic [4:0] a2,
                         input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                         input logic stall, input logic flush, input logic [4:0] dbga);
        e_t nx;
        @(negedge clk);
        D_valid = dv; D_rs1_addr = a1; D_rs2_addr = a2;
        W_reg_write = wr; W_rd_addr = wa; W_rd = wd;
        E_stall = stall; E_flush = flush; dbg_addr = dbga;
        #1;
        chk("dbg_data", dbg_data, model_read(dbga));
        if (flush) begin
            nx = '{v: 1'b0, a1: 5'd0, a2: 5'd0, d1: 32'h0, d2: 32'h0};
        end else if (stall) begin
            nx = ref_e;
            if (wr && ref_e.a1 != 5'd0 && ref_e.a1 == wa) nx.d1 = wd;
            if (wr && ref_e.a2 != 5'd0 && ref_e.a2 == wa) nx.d2 = wd;
        end else begin
            nx = '{v: dv, a1: a1, a2: a2, d1: model_read(a1), d2: model_read(a2)};
        end
        if (wr && wa != 5'd0) ref_regs[wa] = wd;
        ref_e = nx;
        sb_q.push_back(nx);
    endtask

    // Wait for the edge that consumes the last queued cycle and for the monitor to check it.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every rising edge presents a new E register value.
    initial begin
        e_t ex;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                ex = sb_q.pop_front();
                chk("E_valid",    {31'h0, E_valid},    {31'h0, ex.v});
                chk("E_rs1_addr", {27'h0, E_rs1_addr}, {27'h0, ex.a1});
                chk("E_rs2_addr", {27'h0, E_rs2_addr}, {27'h0, ex.a2});
                chk("E_rs1_data", E_rs1_data, ex.d1);
                chk("E_rs2_data", E_rs2_data, ex.d2);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        D_valid = 0; D_rs1_addr = 0; D_rs2_addr = 0;
        W_reg_write = 0; W_rd_addr = 0; W_rd = 0;
        E_stall = 0; E_flush = 0; dbg_addr = 5'd5;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset E_valid", {31'h0, E_valid}, 32'h0);
        chk("reset E_rs1_data", E_rs1_data, 32'h0);
        chk("reset dbg x5", dbg_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read.
        cycle(0, 5'd0, 5'd0, 1, 5'd3, 32'hDEADBEEF, 0, 0, 5'd0);
        cycle(1, 5'd3, 5'd0, 0, 5'd0, 32'h0, 0, 0, 5'd3);
        settle();
        chk("x3 read E_rs1_data", E_rs1_data, 32'hDEADBEEF);
        chk("x3 read E_valid", {31'h0, E_valid}, 32'h1);

        // Same-cycle bypass, then x0 write discarded.
        cycle(1, 5'd3, 5'd7, 1, 5'd7, 32'h12345678, 0, 0, 5'd7);
        settle();
        chk("bypass E_rs2_data", E_rs2_data, 32'h12345678);
        cycle(1, 5'd0, 5'd7, 1, 5'd0, 32'hFFFFFFFF, 0, 0, 5'd0);
        settle();
        chk("x0 E_rs1_data", E_rs1_data, 32'h0);
        cycle(0, 5'd0, 5'd0, 0, 5'd0, 32'h0, 0, 0, 5'd0);
        settle();
        chk("x0 dbg", dbg_data, 32'h0);

        // Stall refresh of a held operand.
        cycle(0, 5'd0, 5'd0, 1, 5'd9, 32'h1, 0, 0, 5'd9);
        cycle(1, 5'd9, 5'd3, 0, 5'd0, 32'h0, 0, 0, 5'd9);
        cycle(0, 5'd1, 5'd1, 1, 5'd9, 32'hAAAA5555, 1, 0, 5'd9);
        settle();
        chk("stall refresh rs1", E_rs1_data, 32'hAAAA5555);
        chk("stall hold rs2", E_rs2_data, 32'hDEADBEEF);
        chk("stall hold valid", {31'h0, E_valid}, 32'h1);

        // Flush beats stall.
        cycle(1, 5'd3, 5'd9, 0, 5'd0, 32'h0, 1, 1, 5'd3);
        settle();
        chk("flush E_valid", {31'h0, E_valid}, 32'h0);
        chk("flush E_rs2_data", E_rs2_data, 32'h0);

        // Reset mid-operation.
        cycle(1, 5'd4, 5'd3, 1, 5'd4, 32'h55, 0, 0, 5'd4);
        cycle(1, 5'd4, 5'd3, 0, 5'd0, 32'h0, 0, 0, 5'd4);
        settle();
        chk("pre-reset x4", E_rs1_data, 32'h55);
        @(negedge clk);
        W_reg_write = 0; E_stall = 0; E_flush = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset E_valid", {31'h0, E_valid}, 32'h0);
        chk("async reset E_rs1_data", E_rs1_data, 32'h0);
        rst_n = 1'b1;
        model_reset();
        cycle(1, 5'd4, 5'd4, 0, 5'd0, 32'h0, 0, 0, 5'd4);
        settle();
        chk("post-reset x4", E_rs1_data, 32'h0);

        // Randomized traffic, addresses biased to a small set to exercise bypass/refresh.
        for (int n = 0; n < 600; n++) begin
            logic [4:0] a1, a2, wa, da;
            a1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 5)) : 5'($urandom);
            a2 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 5)) : 5'($urandom);
            wa = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 5)) : 5'($urandom);
            da = 5'($urandom_range(0, 7));
            cycle(1'($urandom), a1, a2, ($urandom_range(0, 3) != 0), wa, $urandom,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), da);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard drained", 32'(sb_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_decode_operand_unit
